// File: rtl/switching_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switching_gen_pkg
// Description : Shared definitions for the switching keystream generator
//               family: FSM state encoding, default parameter constants and
//               the GF(2) row dot-product helper.
// Revision    : 1.0 - initial release
// ============================================================================
package switching_gen_pkg;

  // Generator operating states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // Default parameter set shared by the data-unit family
  localparam int DEF_N      = 16;
  localparam int DEF_M      = 8;
  localparam int DEF_W      = 8;
  localparam int DEF_WARMUP = 32;

  // Widest data state the row helper supports
  localparam int MAX_M      = 64;

  // One row of a GF(2) matrix-vector product: parity of (row AND x).
  // Callers zero-extend narrower rows/vectors to MAX_M bits.
  function automatic logic gf2_dot(input logic [MAX_M-1:0] row,
                                   input logic [MAX_M-1:0] x);
    return ^(row & x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf2_matvec.sv
`default_nettype none
// ============================================================================
// Module      : gf2_matvec
// Description : Combinational GF(2) matrix-vector product y = Mat * x.
//               Row i of the matrix is i_mat[i*M +: M], bit j = column j.
// Revision    : 1.0 - initial release
// ============================================================================
module gf2_matvec
  import switching_gen_pkg::*;
#(
  parameter int M = DEF_M
) (
  input  logic [M*M-1:0] i_mat,
  input  logic [M-1:0]   i_x,
  output logic [M-1:0]   o_y
);

  // One output bit per matrix row
  for (genvar gi = 0; gi < M; gi++) begin : g_row
    assign o_y[gi] = gf2_dot(MAX_M'(i_mat[gi*M +: M]), MAX_M'(i_x));
  end

endmodule
`default_nettype wire

// File: rtl/switching_keystream_gen.sv
`default_nettype none
// ============================================================================
// Module      : switching_keystream_gen
// Description : Word-output switching keystream generator. A control LFSR
//               picks matrix A or B each step to advance the data state; the
//               state LSB is the keystream bit. Bits are packed MSB-first
//               into W-bit words behind a valid/ready output register, with
//               warm-up discard, seed validation and live reseed.
// Revision    : 1.0 - initial release
// ============================================================================
module switching_keystream_gen
  import switching_gen_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int M      = DEF_M,
  parameter int W      = DEF_W,
  parameter int WARMUP = DEF_WARMUP
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           seed_load,
  input  logic [N-1:0]   ctrl_init,
  input  logic [N-1:0]   ctrl_taps,
  input  logic [M-1:0]   data_init,
  input  logic [M*M-1:0] mat_a,
  input  logic [M*M-1:0] mat_b,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           seed_err
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam int WC_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(W - 1);
  localparam logic [WC_W-1:0]  c_warm_last = WC_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

  // Architectural state
  state_t           r_state;
  logic [N-1:0]     r_ctrl;
  logic [N-1:0]     r_taps;
  logic [M-1:0]     r_x;
  logic [M*M-1:0]   r_mat_a;
  logic [M*M-1:0]   r_mat_b;
  logic [WC_W-1:0]  r_wcnt;
  logic [W-1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_out_data;
  logic             r_out_valid;
  logic             r_seed_err;

  // Step datapath
  logic             w_seed_ok;
  logic             w_c;
  logic             w_fb;
  logic [N-1:0]     w_ctrl_next;
  logic [M-1:0]     w_y_a;
  logic [M-1:0]     w_y_b;
  logic [M-1:0]     w_x_next;
  logic [W-1:0]     w_acc_next;
  logic             w_word_done;
  logic             w_handshake;
  logic             w_stall;
  logic             w_step_en;

  // A seed is usable only if neither the LFSR nor the data state starts at zero
  assign w_seed_ok   = (|ctrl_init) && (|data_init);

  // Control LFSR: MSB selects the matrix, feedback enters at the LSB
  assign w_c         = r_ctrl[N-1];
  assign w_fb        = ^(r_ctrl & r_taps);
  assign w_ctrl_next = {r_ctrl[N-2:0], w_fb};

  gf2_matvec #(.M(M)) u_mv_a (
    .i_mat (r_mat_a),
    .i_x   (r_x),
    .o_y   (w_y_a)
  );

  gf2_matvec #(.M(M)) u_mv_b (
    .i_mat (r_mat_b),
    .i_x   (r_x),
    .o_y   (w_y_b)
  );

  assign w_x_next    = w_c ? w_y_b : w_y_a;

  // Keystream bit (current x LSB) enters the accumulator from the bottom, so
  // the first bit of a word ends up in the MSB after W shifts.
  assign w_acc_next  = (r_acc << 1) | W'(r_x[0]);

  assign w_word_done = (r_cnt == c_cnt_last);
  assign w_handshake = r_out_valid && out_ready;

  // Only stall when a word would complete while the output slot is still full
  assign w_stall     = w_word_done && r_out_valid && !out_ready;
  assign w_step_en   = (r_state == ST_WARMUP) ||
                       ((r_state == ST_RUN) && !w_stall);

  // FSM, generator state, bit packer and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ctrl      <= '0;
      r_taps      <= '0;
      r_x         <= '0;
      r_mat_a     <= '0;
      r_mat_b     <= '0;
      r_wcnt      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_seed_err  <= 1'b0;
    end else if (seed_load) begin
      // A seed overrides any in-flight word completion; a word handshaked
      // this same cycle has already been taken by the consumer.
      r_out_valid <= 1'b0;
      if (w_seed_ok) begin
        r_ctrl     <= ctrl_init;
        r_taps     <= ctrl_taps;
        r_x        <= data_init;
        r_mat_a    <= mat_a;
        r_mat_b    <= mat_b;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_wcnt     <= c_warm_last;
        r_seed_err <= 1'b0;
        r_state    <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      end else begin
        r_seed_err <= 1'b1;
        r_state    <= ST_IDLE;
      end
    end else begin
      // Drain; a word completing this same cycle re-asserts valid below
      if (w_handshake) begin
        r_out_valid <= 1'b0;
      end

      if (w_step_en) begin
        r_ctrl <= w_ctrl_next;
        r_x    <= w_x_next;
      end

      case (r_state)
        ST_WARMUP: begin
          if (r_wcnt == '0) begin
            r_state <= ST_RUN;
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (w_step_en) begin
            r_acc <= w_acc_next;
            if (w_word_done) begin
              r_out_data  <= w_acc_next;
              r_out_valid <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);
  assign seed_err  = r_seed_err;

endmodule
`default_nettype wire

// File: tb/tb_switching_keystream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_switching_keystream_gen
// Description : Self-checking bench. Two generator instances (N4/M2/W4 with
//               no warm-up, and N16/M8/W8 with 32-step warm-up) share their
//               inputs; a keystream model produces the expected bit stream
//               and every accepted word is compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switching_keystream_gen;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] ctrl_init;
  logic [15:0] ctrl_taps;
  logic [7:0]  data_init;
  logic [63:0] mat_a;
  logic [63:0] mat_b;
  logic        out_ready;

  logic [3:0]  s_out_data;
  logic        s_out_valid, s_busy, s_seed_err;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_busy, b_seed_err;

  // Selected instance under observation (0 = small, 1 = big)
  bit          sel;
  logic [7:0]  o_data;
  logic        o_valid, o_busy, o_err;

  assign o_data  = sel ? b_out_data  : {4'b0000, s_out_data};
  assign o_valid = sel ? b_out_valid : s_out_valid;
  assign o_busy  = sel ? b_busy      : s_busy;
  assign o_err   = sel ? b_seed_err  : s_seed_err;

  int total = 0;
  int bad   = 0;

  switching_keystream_gen #(.N(4), .M(2), .W(4), .WARMUP(0)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .ctrl_init (ctrl_init[3:0]),
    .ctrl_taps (ctrl_taps[3:0]),
    .data_init (data_init[1:0]),
    .mat_a     (mat_a[3:0]),
    .mat_b     (mat_b[3:0]),
    .out_data  (s_out_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .busy      (s_busy),
    .seed_err  (s_seed_err)
  );

  switching_keystream_gen #(.N(16), .M(8), .W(8), .WARMUP(32)) u_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .ctrl_init (ctrl_init),
    .ctrl_taps (ctrl_taps),
    .data_init (data_init),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .busy      (b_busy),
    .seed_err  (b_seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- keystream model ----------------
  int          mn, mm, mw, mwarm;
  logic [63:0] m_ctrl, m_taps, m_x, m_a, m_b;
  logic        m_err;

  function automatic void set_model(int n, int m, int w, int warm);
    mn = n; mm = m; mw = w; mwarm = warm;
  endfunction

  // One generator step: returns the emitted bit and advances the model
  function automatic logic model_bit();
    logic [63:0] nmask = (64'd1 << mn) - 1;
    logic [63:0] xmask = (64'd1 << mm) - 1;
    logic [63:0] mat, row, nx;
    logic        c, fb, z;
    c      = m_ctrl[mn-1];
    fb     = ($countones(m_ctrl & m_taps) % 2) == 1;
    mat    = c ? m_b : m_a;
    z      = m_x[0];
    nx     = 0;
    for (int i = 0; i < mm; i++) begin
      row = (mat >> (i * mm)) & xmask;
      if (($countones(row & m_x) % 2) == 1) nx = nx | (64'd1 << i);
    end
    m_ctrl = ((m_ctrl << 1) | {63'd0, fb}) & nmask;
    m_x    = nx;
    return z;
  endfunction

  function automatic logic [63:0] model_word();
    logic [63:0] w = 0;
    for (int k = 0; k < mw; k++) w = (w << 1) | {63'd0, model_bit()};
    return w;
  endfunction

  function automatic void model_seed();
    logic [63:0] nmask = (64'd1 << mn) - 1;
    logic [63:0] xmask = (64'd1 << mm) - 1;
    m_err = ((64'(ctrl_init) & nmask) == 0) || ((64'(data_init) & xmask) == 0);
    if (!m_err) begin
      m_ctrl = 64'(ctrl_init) & nmask;
      m_taps = 64'(ctrl_taps) & nmask;
      m_x    = 64'(data_init) & xmask;
      m_a    = mat_a;
      m_b    = mat_b;
      for (int k = 0; k < mwarm; k++) void'(model_bit());
    end
  endfunction

  // Row i shifts in column i+1 (cyclic): invertible permutation
  function automatic logic [63:0] mk_shift();
    logic [63:0] r = 0;
    for (int i = 0; i < 8; i++) r[i*8 + ((i + 1) % 8)] = 1'b1;
    return r;
  endfunction

  // Companion matrix with last row = poly (bit 0 forced for invertibility)
  function automatic logic [63:0] mk_comp(input logic [7:0] poly);
    logic [63:0] r = 0;
    for (int i = 0; i < 7; i++) r[i*8 + i + 1] = 1'b1;
    r[63:56] = poly | 8'h01;
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_seed(input logic [15:0] ci, input logic [15:0] ct, input logic [7:0] di,
                         input logic [63:0] ma, input logic [63:0] mb);
    ctrl_init = ci; ctrl_taps = ct; data_init = di; mat_a = ma; mat_b = mb;
    seed_load = 1'b1;
    model_seed();
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  task automatic wait_first_valid(output int k, output logic v0, output logic b0, input int budget);
    out_ready = 1'b0;
    k  = 0;
    v0 = o_valid;
    b0 = o_busy;
    while (!o_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_words(input string tag, input int nw, input int pct, input int budget);
    int         got = 0;
    int         cyc = 0;
    logic       hold = 1'b0;
    logic [7:0] hd = '0;
    while (got < nw && cyc < budget) begin
      if (hold) begin
        check({tag, "_hold_valid"}, o_valid, 1);
        check({tag, "_hold_data"}, o_data, hd);
      end
      out_ready = ($urandom_range(99) < pct);
      if (o_valid && out_ready) begin
        check({tag, "_word"}, o_data, model_word());
        got++;
      end
      hold = o_valid && !out_ready;
      hd   = o_data;
      @(negedge clk);
      cyc++;
    end
    if (got < nw) check({tag, "_budget"}, got, nw);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         k;
    logic       v0, b0;
    logic [7:0] d0;

    rst_n = 1'b0; seed_load = 1'b0; out_ready = 1'b0;
    ctrl_init = '0; ctrl_taps = '0; data_init = '0; mat_a = '0; mat_b = '0;
    sel = 1'b0;
    set_model(4, 2, 4, 0);
    repeat (2) @(negedge clk);

    // Reset values on both instances
    check("rst_s_valid", s_out_valid, 0);
    check("rst_s_busy",  s_busy, 0);
    check("rst_s_err",   s_seed_err, 0);
    check("rst_s_data",  s_out_data, 0);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_b_data",  b_out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity matrices: constant all-ones stream, first word W cycles after RUN entry
    do_seed(16'h0001, 16'h0009, 8'h01, 64'h9, 64'h9);
    check("t2_busy", o_busy, 1);
    wait_first_valid(k, v0, b0, 50);
    check("t2_first_lat", k, 4);
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      check("t2_word_model", o_data, model_word());
      check("t2_word_F", o_data, 8'h0F);
      @(negedge clk);
      k = 1;
      while (!o_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("t2_interval", k, 4);
    end

    // Reset mid-RUN
    rst_n = 1'b0;
    @(negedge clk);
    check("t1_valid", s_out_valid, 0);
    check("t1_busy",  s_busy, 0);
    check("t1_err",   s_seed_err, 0);
    check("t1_data",  s_out_data, 0);
    check("t1_b_busy", b_busy, 0);
    // Seed presented while reset is still asserted is ignored
    ctrl_init = 16'h0003; data_init = 8'h01; seed_load = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    seed_load = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_seed_ignored_busy", s_busy, 0);
    check("t1_seed_ignored_valid", s_out_valid, 0);

    // Back-pressure: word held stable while generator stalls, then no lost bits
    do_seed(16'h0005, 16'h0009, 8'h01, 64'h6, 64'h7);
    wait_first_valid(k, v0, b0, 50);
    check("t3_first_lat", k, 4);
    d0 = o_data;
    check("t3_held_word", d0, model_word());
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_hold_valid", o_valid, 1);
      check("t3_hold_data", o_data, d0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    run_words("t3_resume", 10, 100, 200);
    run_words("t3_rand", 20, 50, 600);

    // Invalid seeds: zero control, zero data, and mid-RUN rejection
    do_seed(16'h0000, 16'h0009, 8'h01, 64'h6, 64'h7);
    check("t4_err_ctrl", o_err, m_err);
    check("t4_busy_ctrl", o_busy, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_no_valid", o_valid, 0);
    end
    do_seed(16'h0003, 16'h0009, 8'h00, 64'h6, 64'h7);
    check("t4_err_data", o_err, m_err);
    do_seed(16'h000B, 16'h0009, 8'h02, 64'h6, 64'h7);
    check("t4_err_clear", o_err, 0);
    check("t4_busy_valid", o_busy, 1);
    wait_first_valid(k, v0, b0, 50);
    check("t4_first_lat", k, 4);
    do_seed(16'h0000, 16'h0000, 8'h02, 64'h6, 64'h7);
    check("t4_mid_err", o_err, 1);
    check("t4_mid_busy", o_busy, 0);
    check("t4_mid_valid", o_valid, 0);

    // Big instance: warm-up latency, then reseed on a handshake cycle
    sel = 1'b1;
    set_model(16, 8, 8, 32);
    do_seed(16'hACE1, 16'hB400, 8'h5A, mk_shift(), mk_comp(8'h1D));
    wait_first_valid(k, v0, b0, 200);
    check("t5_first_lat", k, 40);
    run_words("t5_pre", 5, 100, 200);
    out_ready = 1'b1;
    k = 0;
    while (!o_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_hs_word", o_data, model_word());
    do_seed(16'h1234, 16'hD008, 8'hC3, mk_comp(8'h8E), mk_shift());
    wait_first_valid(k, v0, b0, 200);
    check("t5_after_valid", v0, 0);
    check("t5_after_busy", b0, 1);
    check("t5_restart_lat", k, 40);
    run_words("t5_post", 20, 70, 400);

    // Long randomized run against the model
    do_seed(16'($urandom_range(1, 65535)), 16'($urandom_range(0, 65535)) | 16'h8000,
            8'($urandom_range(1, 255)), mk_shift(), mk_comp(8'($urandom_range(0, 255))));
    run_words("t6", 1500, 60, 40000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
